fdiv_seq: RTL and testbench

Multi-cycle single-precision divider controller. It time-multiplexes one N×N fixed-point multiplier across the five Goldschmidt products (e, t1, t2, t3, t4), sequences them with a one-hot state machine, and packs sign, exponent and mantissa into a 32-bit result. It also maintains sticky underflow/overflow flags. It sits between the instruction-issue logic (div_op_en pulse) and the register file write-back, and replaces the fully combinational five-multiplier divide path.

---
 rtl/fdiv_seq.sv | 170 +++++++++++++++++
 tb/tb_fdiv_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider: one shared N x N multiplier stepped through
// the five Goldschmidt products, then normalization, exponent checks and packing.

module LutDiv (
   input  logic [7:0]  idx,
   output logic [23:0] lut_div
);
   // Reciprocal of each interval midpoint 1 + (idx + 0.5)/256, as Q0.24.
   localparam logic [33:0] NUM = 34'h2_0000_0000;
   logic [23:0] rom [256];

   for (genvar g = 0; g < 256; g++) begin : g_rom
      assign rom[g] = 24'(NUM / 34'(513 + 2 * g));
   end

   assign lut_div = rom[idx];
endmodule

module fdiv_seq #(
   parameter int N     = 40,
   parameter int FP_DW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_op_en,
   input  logic [FP_DW-1:0] div_rb,
   input  logic [FP_DW-1:0] div_rc,
   output logic             div_busy,
   output logic             div_done,
   output logic [FP_DW-1:0] div_ra,
   input  logic             div_luf_clr,
   input  logic             div_lvf_clr,
   output logic             div_luf_flag,
   output logic             div_lvf_flag
);
   typedef enum logic [6:0] {
      IDLE   = 7'b000_0001,
      MUL_E  = 7'b000_0010,
      MUL_T1 = 7'b000_0100,
      MUL_T2 = 7'b000_1000,
      MUL_T3 = 7'b001_0000,
      MUL_T4 = 7'b010_0000,
      PACK   = 7'b100_0000
   } state_t;

   state_t state, state_nx;

   logic         s_r;
   logic [7:0]   eb_r, ec_r;
   logic [N-1:0] b_r, c_r, u_r, e_r, e_neg_r, t1_r, t2_r, t3_r, t4_r;
   logic [23:0]  lut_div;

   logic [N-1:0]   mul_a, mul_b, t1_neg, rnd;
   logic [2*N-1:0] prod;

   logic [22:0]      mant;
   logic             adj;
   logic [9:0]       exp_v;
   logic [FP_DW-1:0] pack_res;
   logic             pack_luf, pack_lvf;
   logic             unused_bits;

   LutDiv u_lut (
      .idx     (div_rc[22:15]),
      .lut_div (lut_div)
   );

   assign t1_neg = ~t1_r + N'(1);
   assign prod   = {{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b};
   assign rnd    = prod[2*N-2:N-1] + {{(N-1){1'b0}}, prod[N-2]};
   assign unused_bits = ^{prod[2*N-1], prod[N-3:0], t4_r[N-25:0]};

   assign div_busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mul_a    = '0;
      mul_b    = '0;
      unique case (state)
         IDLE:   if (div_op_en) state_nx = MUL_E;
         MUL_E:  begin mul_a = u_r;     mul_b = c_r;     state_nx = MUL_T1; end
         MUL_T1: begin mul_a = e_r;     mul_b = e_neg_r; state_nx = MUL_T2; end
         MUL_T2: begin mul_a = e_neg_r; mul_b = t1_neg;  state_nx = MUL_T3; end
         MUL_T3: begin mul_a = u_r;     mul_b = b_r;     state_nx = MUL_T4; end
         MUL_T4: begin mul_a = t2_r;    mul_b = t3_r;    state_nx = PACK;   end
         PACK:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Exponent is evaluated in 10 bits so bit 9 acts as the sign of the biased result.
   always_comb begin
      adj      = ~t4_r[N-1];
      mant     = t4_r[N-1] ? t4_r[N-2 -: 23] : t4_r[N-3 -: 23];
      exp_v    = {2'b00, eb_r} - {2'b00, ec_r} + 10'd127 - {9'b0, adj};
      pack_res = {s_r, exp_v[7:0], mant};
      pack_luf = 1'b0;
      pack_lvf = 1'b0;
      if (eb_r == '0) begin
         pack_res = {s_r, 31'b0};
      end else if (ec_r == '0) begin
         pack_res = {s_r, 8'hFF, 23'b0};
         pack_lvf = 1'b1;
      end else if (!exp_v[9] && exp_v[8:0] >= 9'd255) begin
         pack_res = {s_r, 8'hFF, 23'b0};
         pack_lvf = 1'b1;
      end else if (exp_v[9] || exp_v == '0) begin
         pack_res = {s_r, 31'b0};
         pack_luf = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r     <= 1'b0;
         eb_r    <= '0;
         ec_r    <= '0;
         b_r     <= '0;
         c_r     <= '0;
         u_r     <= '0;
         e_r     <= '0;
         e_neg_r <= '0;
         t1_r    <= '0;
         t2_r    <= '0;
         t3_r    <= '0;
         t4_r    <= '0;
         div_ra  <= '0;
      end else begin
         unique case (state)
            IDLE: if (div_op_en) begin
               s_r  <= div_rb[31] ^ div_rc[31];
               eb_r <= div_rb[30:23];
               ec_r <= div_rc[30:23];
               b_r  <= {1'b1, div_rb[22:0], {(N-24){1'b0}}};
               c_r  <= {1'b1, div_rc[22:0], {(N-24){1'b0}}};
               u_r  <= {1'b0, lut_div, {(N-25){1'b0}}};
            end
            MUL_E: begin
               e_r     <= rnd;
               e_neg_r <= ~rnd + N'(1);
            end
            MUL_T1: t1_r   <= rnd;
            MUL_T2: t2_r   <= rnd;
            MUL_T3: t3_r   <= rnd;
            MUL_T4: t4_r   <= rnd;
            PACK:   div_ra <= pack_res;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_done     <= 1'b0;
         div_luf_flag <= 1'b0;
         div_lvf_flag <= 1'b0;
      end else begin
         div_done <= (state == PACK);
         if (state == PACK && pack_luf) div_luf_flag <= 1'b1;
         else if (div_luf_clr)          div_luf_flag <= 1'b0;
         if (state == PACK && pack_lvf) div_lvf_flag <= 1'b1;
         else if (div_lvf_clr)          div_lvf_flag <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: timing, special cases, sticky flags, busy-hold,
// asynchronous abort and back-to-back operands against a fixed-point reference.

module tb_fdiv_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        div_op_en = 1'b0;
   logic [31:0] div_rb = '0, div_rc = '0;
   logic        div_luf_clr = 1'b0, div_lvf_clr = 1'b0;
   logic        div_busy, div_done, div_luf_flag, div_lvf_flag;
   logic [31:0] div_ra;

   int total = 0;
   int bad   = 0;

   fdiv_seq #(.N(40), .FP_DW(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .div_op_en    (div_op_en),
      .div_rb       (div_rb),
      .div_rc       (div_rc),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .div_ra       (div_ra),
      .div_luf_clr  (div_luf_clr),
      .div_lvf_clr  (div_lvf_clr),
      .div_luf_flag (div_luf_flag),
      .div_lvf_flag (div_lvf_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] rnd(input logic [39:0] a, input logic [39:0] b);
      logic [79:0] k;
      k = {40'b0, a} * {40'b0, b};
      return k[78:39] + {39'b0, k[38]};
   endfunction

   // Returns {luf, lvf, quotient}.
   function automatic logic [33:0] model(input logic [31:0] rb, input logic [31:0] rc);
      logic [33:0] den;
      logic [23:0] lut;
      logic [39:0] u, b, c, e, en, t1, t2, t3, t4;
      logic [22:0] mant;
      logic        s;
      int          adj, ex;
      den  = 34'd513 + {25'd0, rc[22:15], 1'b0};
      lut  = 24'(34'h2_0000_0000 / den);
      u    = {1'b0, lut, 15'b0};
      b    = {1'b1, rb[22:0], 16'b0};
      c    = {1'b1, rc[22:0], 16'b0};
      e    = rnd(u, c);
      en   = ~e + 40'd1;
      t1   = rnd(e, en);
      t2   = rnd(en, ~t1 + 40'd1);
      t3   = rnd(u, b);
      t4   = rnd(t2, t3);
      if (t4[39]) begin mant = t4[38:16]; adj = 0; end
      else        begin mant = t4[37:15]; adj = 1; end
      ex = int'(rb[30:23]) - int'(rc[30:23]) + 127 - adj;
      s  = rb[31] ^ rc[31];
      if (rb[30:23] == 8'd0)      return {2'b00, s, 31'b0};
      else if (rc[30:23] == 8'd0) return {2'b01, s, 8'hFF, 23'b0};
      else if (ex >= 255)         return {2'b01, s, 8'hFF, 23'b0};
      else if (ex <= 0)           return {2'b10, s, 31'b0};
      else                        return {2'b00, s, ex[7:0], mant};
   endfunction

   // Starts at a negedge; returns at the negedge where div_done is seen (or the bound expires).
   task automatic run(input logic [31:0] rb, input logic [31:0] rc, input string tag);
      int n;
      logic [33:0] m;
      m = model(rb, rc);
      div_rb = rb; div_rc = rc; div_op_en = 1'b1;
      @(negedge clk);
      div_op_en = 1'b0;
      n = 1;
      check({tag, "_busy1"}, div_busy, 1);
      while (!div_done && n < 12) begin @(negedge clk); n++; end
      check({tag, "_latency"}, n, 7);
      check({tag, "_ra"}, div_ra, m[31:0]);
   endtask

   initial begin
      logic [33:0] m;
      logic [31:0] a, c, rb, rc;
      int dones, diff;

      repeat (2) @(negedge clk);
      check("rst_busy", div_busy, 0);
      check("rst_done", div_done, 0);
      check("rst_ra", div_ra, 0);
      check("rst_luf", div_luf_flag, 0);
      check("rst_lvf", div_lvf_flag, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 6.0 / 2.0 with cycle-by-cycle handshake checks
      m = model(32'h40C00000, 32'h40000000);
      div_rb = 32'h40C00000; div_rc = 32'h40000000; div_op_en = 1'b1;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) div_op_en = 1'b0;
         check($sformatf("t62_busy_c%0d", cyc), div_busy, (cyc <= 6) ? 1 : 0);
         check($sformatf("t62_done_c%0d", cyc), div_done, (cyc == 7) ? 1 : 0);
         if (cyc == 7) begin
            check("t62_ra_model", div_ra, m[31:0]);
            diff = int'(div_ra) - int'(32'h40400000);
            check("t62_ulp", (diff >= -1 && diff <= 1) ? 1 : 0, 1);
         end
      end

      run(32'h00000000, 32'h40000000, "zero_div");
      check("zero_ra", div_ra, 32'h00000000);
      check("zero_luf", div_luf_flag, 0);
      check("zero_lvf", div_lvf_flag, 0);

      run(32'hC0000000, 32'h00000000, "divz");
      check("divz_ra", div_ra, 32'hFF800000);
      check("divz_lvf", div_lvf_flag, 1);
      check("divz_luf", div_luf_flag, 0);
      div_lvf_clr = 1'b1;
      @(negedge clk);
      div_lvf_clr = 1'b0;
      check("lvf_clr", div_lvf_flag, 0);

      run(32'h7F000000, 32'h00800000, "ovf");
      check("ovf_ra", div_ra, 32'h7F800000);
      check("ovf_lvf", div_lvf_flag, 1);

      run(32'h00800000, 32'h7F000000, "unf");
      check("unf_ra", div_ra, 32'h00000000);
      check("unf_luf", div_luf_flag, 1);
      check("unf_lvf_kept", div_lvf_flag, 1);

      run(32'h40C00000, 32'h40000000, "sticky");
      check("sticky_luf", div_luf_flag, 1);
      check("sticky_lvf", div_lvf_flag, 1);

      div_luf_clr = 1'b1;
      @(negedge clk);
      div_luf_clr = 1'b0;
      check("luf_clr", div_luf_flag, 0);
      check("luf_clr_lvf", div_lvf_flag, 1);

      // clear pulse coincides with the underflow PACK edge: set must win
      div_rb = 32'h00800000; div_rc = 32'h7F000000; div_op_en = 1'b1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         if (cyc == 1) div_op_en = 1'b0;
         if (cyc == 6) div_luf_clr = 1'b1;
         if (cyc == 7) begin
            div_luf_clr = 1'b0;
            check("clrset_done", div_done, 1);
            check("clrset_luf", div_luf_flag, 1);
         end
      end
      div_luf_clr = 1'b1; div_lvf_clr = 1'b1;
      @(negedge clk);
      div_luf_clr = 1'b0; div_lvf_clr = 1'b0;
      check("clr_both", {div_luf_flag, div_lvf_flag}, 0);

      // div_op_en held for 20 cycles, operands change while busy
      a = 32'h40C00000; c = 32'h40000000;
      div_rb = a; div_rc = c; div_op_en = 1'b1;
      dones = 0;
      for (int i = 1; i <= 28; i++) begin
         @(negedge clk);
         if (i == 2) div_rb = 32'h41200000;
         if (i == 20) div_op_en = 1'b0;
         if (div_done) begin
            dones++;
            if (i == 7) check("hold_r1", div_ra, model(a, c) & 34'hFFFFFFFF);
            else        check($sformatf("hold_r_at%0d", i), div_ra,
                              model(32'h41200000, c) & 34'hFFFFFFFF);
            check($sformatf("hold_slot_%0d", i), (i % 7 == 0) ? 1 : 0, 1);
         end
      end
      check("hold_dones", dones, 3);

      // back-to-back random normal operands
      for (int i = 0; i < 1000; i++) begin
         rb = {$urandom_range(1, 0) == 1, 8'($urandom_range(190, 64)), 23'($urandom)};
         rc = {$urandom_range(1, 0) == 1, 8'($urandom_range(190, 64)), 23'($urandom)};
         run(rb, rc, $sformatf("rnd%0d", i));
      end
      @(negedge clk);
      check("rnd_idle_done", div_done, 0);

      // asynchronous abort in cycle 3
      run(32'h7F000000, 32'h00800000, "pre_abort");
      div_rb = 32'h40C00000; div_rc = 32'h40000000; div_op_en = 1'b1;
      @(negedge clk);
      div_op_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", div_busy, 0);
      check("abort_done", div_done, 0);
      check("abort_ra", div_ra, 0);
      check("abort_lvf", div_lvf_flag, 0);
      check("abort_luf", div_luf_flag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (div_done) dones++;
      end
      check("abort_no_done", dones, 0);
      run(32'h40C00000, 32'h40000000, "post_abort");
      check("post_abort_flags", {div_luf_flag, div_lvf_flag}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
